// File: rtl/seq_mult_nxn.sv
// Sequential shift-add WIDTH x WIDTH multiplier with a start/busy/done handshake, signed or unsigned per operation.
// Define SEQ_MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module seq_mult_nxn #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     M,
    input  logic [WIDTH-1:0]     Q,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   mm_q, mq_q, acc_q;
    logic               neg_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q, done_q;
    logic [2*WIDTH-1:0] p_q;

    logic [WIDTH-1:0]   mag_m_d, mag_q_d, acc_d, mq_d;
    logic               neg_d, last;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod, res;

    // Magnitudes fit WIDTH bits unsigned, so -2^(W-1) maps cleanly to 2^(W-1).
    always_comb begin
        mag_m_d = (signed_mode && M[WIDTH-1]) ? -M : M;
        mag_q_d = (signed_mode && Q[WIDTH-1]) ? -Q : Q;
        neg_d   = signed_mode & (M[WIDTH-1] ^ Q[WIDTH-1]);
    end

`ifdef SEQ_MULT_EARLY_TERM_EN
    logic [CW-1:0] shamt;
    logic          rem_nz;
    always_comb begin
        sum    = {1'b0, acc_q} + ({1'b0, mm_q} & {(WIDTH+1){mq_q[0]}});
        acc_d  = sum[WIDTH:1];
        mq_d   = {sum[0], mq_q[WIDTH-1:1]};
        shamt  = CW'(WIDTH-1) - cnt_q;
        rem_nz = 1'b0;
        // Low 'shamt' bits of the shifted multiplier are the bits not yet consumed.
        for (int i = 0; i < WIDTH-1; i++)
            if (CW'(i) < shamt && mq_q[i+1]) rem_nz = 1'b1;
        last   = ~rem_nz;
        prod   = {acc_d, mq_d} >> shamt;
        res    = neg_q ? -prod : prod;
    end
`else
    always_comb begin
        sum   = {1'b0, acc_q} + ({1'b0, mm_q} & {(WIDTH+1){mq_q[0]}});
        acc_d = sum[WIDTH:1];
        mq_d  = {sum[0], mq_q[WIDTH-1:1]};
        last  = (cnt_q == CW'(WIDTH-1));
        prod  = {acc_d, mq_d};
        res   = neg_q ? -prod : prod;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mm_q    <= '0;
            mq_q    <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            p_q     <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mm_q    <= mag_m_d;
                        mq_q    <= mag_q_d;
                        neg_q   <= neg_d;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    mq_q  <= mq_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        p_q     <= res;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign P    = p_q;
endmodule

// File: doc/seq_mult_nxn.md
Name: seq_mult_nxn

Overview:
- Parametrised sequential shift-add multiplier. It is the successor to the 8x8 combinational array multiplier.
- Computes a WIDTH x WIDTH product over WIDTH iterations, with a start/busy/done handshake.
- Supports unsigned or signed (two's complement) operands, selected per operation.
- Sits in the CPU datapath as the MUL execution unit, replacing the single-cycle array. Operands are latched, so the register file may change them after start.

Parameters:
- WIDTH, 8, operand width in bits. Legal range 2..32; product width is 2*WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE or DONE
- signed_mode  in  1  1 = operands are two's complement; latched with start
- M  in  WIDTH  multiplicand; latched with start
- Q  in  WIDTH  multiplier; latched with start
- busy  out  1  high while state is RUN
- done  out  1  one-cycle pulse; P is valid from this cycle on
- P  out  2*WIDTH  product register; holds its value until the next done

Behaviour:
- Reset, applied at any time including mid-operation:
  - state <= IDLE; P, busy, done <= 0.
  - Internal accumulator, operand registers and counter <= 0.
  - No done pulse is produced for an aborted operation.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at edge k: latch operands, clear the accumulator, counter <= 0, go to RUN.
  - Otherwise stay in IDLE.
- Operand latch:
  - Unsigned mode: mag_m = M, mag_q = Q.
  - Signed mode: mag_m = |M|, mag_q = |Q|, neg = M[WIDTH-1] XOR Q[WIDTH-1].
  - Magnitudes are held in WIDTH bits unsigned, so the most negative value maps to 2^(WIDTH-1) without overflow.
- RUN, one iteration per cycle:
  - If mag_q[0]=1, add mag_m to the upper WIDTH+1 bits of the accumulator.
  - Shift the {carry, acc, mag_q} chain right by 1.
  - counter <= counter + 1.
  - busy=1 for exactly WIDTH cycles.
- Completion: on the edge where counter = WIDTH-1:
  - P <= neg ? -acc_result : acc_result, a 2*WIDTH-bit two's complement negate.
  - Go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - If start=1 in DONE, the new operation is accepted back-to-back (go to RUN, latch new operands). Otherwise go to IDLE.
  - P keeps the last result through IDLE and RUN until the next completion.
- Timing: a start at edge k gives done high in the cycle after edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- start while in RUN is ignored; the operation in flight is unaffected.
- Zero operands are processed normally with full latency; the result is 0, never -0 artefacts.
- No overflow is possible: the full 2*WIDTH product is always representable, including (-2^(W-1))*(-2^(W-1)) = 2^(2W-2).

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- When defined: in RUN, if the remaining unshifted multiplier bits are all zero, completion happens at that edge. The remaining shift is applied in one step, and P and the state transition behave as in normal completion.
- Latency then becomes (index of highest set bit of mag_q)+1 RUN cycles, minimum 1 (mag_q=0 gives 1 RUN cycle). busy deasserts accordingly.
- When undefined: fixed WIDTH RUN cycles; the early-termination logic is absent.

Test Plan:
- Reset during RUN:
  - Stimulus: WIDTH=8, start with M=200, Q=150 unsigned; assert rst 3 cycles later.
  - Required: next cycle busy=0, done=0, P=0; no done pulse afterwards.
- Unsigned basic (WIDTH=8):
  - Stimulus: start at edge k, M=13, Q=11, signed_mode=0.
  - Required: busy high 8 cycles; done high in the cycle after edge k+8; P=143.
  - Stimulus: M=255, Q=255.
  - Required: P=65025 (0xFE01).
- Signed corners (WIDTH=8, signed_mode=1):
  - M=-128, Q=-128 -> P=16384 (0x4000).
  - M=-3, Q=7 -> P=0xFFEB (-21).
  - M=0, Q=-1 -> P=0.
- Back-to-back and ignored start:
  - Stimulus: start 5*6; hold start=1 during the DONE cycle with 9*9.
  - Required: P=30 at the first done, P=81 exactly 9 cycles later.
  - Stimulus: pulse start during RUN.
  - Required: no effect on the result or timing.
- Parametrisation:
  - WIDTH=16: M=0xFFFF, Q=0xFFFF unsigned -> P=0xFFFE0001 after 16 RUN cycles.
  - WIDTH=4, signed: M=-8, Q=7 -> P=0xC8 (-56).
- Early termination (macro defined, WIDTH=8):
  - M=100, Q=3 -> busy for 2 cycles, P=300.
  - Q=0 -> 1 RUN cycle, P=0.
  - Same stimulus with the macro undefined -> 8 RUN cycles, identical P.
